// File: rtl/cart_header_loader_pkg.sv
// Shared iNES header layout, flags word bit positions, error codes and loader states.
// Cart memory and mappers import this so every block decodes the flags identically.
package cart_header_loader_pkg;

  localparam logic [31:0] INES_MAGIC = 32'h1A53454E;  // "NES\x1A", byte 0 in bits [7:0]

  localparam int HDR_BYTES  = 16;
  localparam int HDR_PRG    = 4;
  localparam int HDR_CHR    = 5;
  localparam int HDR_FLAGS6 = 6;
  localparam int HDR_FLAGS7 = 7;

  localparam int FLAG_MAPPER_LSB = 0;
  localparam int FLAG_MAPPER_W   = 8;
  localparam int FLAG_PRG_LSB    = 8;
  localparam int FLAG_CHR_LSB    = 11;
  localparam int FLAG_SIZE_W     = 3;
  localparam int FLAG_VMIRROR    = 14;
  localparam int FLAG_CHR_RAM    = 15;
  localparam int FLAG_BATTERY    = 16;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_MAGIC   = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FLASH,
    REQ,
    WAIT_DATA,
    DECODE,
    DONE,
    ERROR
  } loader_state_t;

  // Returns {is_supported_power_of_two, log2}; only 1, 2, 4 and 8 banks are accepted.
  function automatic logic [3:0] bank_log2(input logic [7:0] n);
    case (n)
      8'd1:    bank_log2 = 4'b1_000;
      8'd2:    bank_log2 = 4'b1_001;
      8'd4:    bank_log2 = 4'b1_010;
      8'd8:    bank_log2 = 4'b1_011;
      default: bank_log2 = 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/cart_header_loader_decode.sv
// Combinational iNES header decoder: 16 header bytes in, flags word and error code out.
module ines_header_decode
  import cart_header_loader_pkg::*;
(
  input  logic [8*HDR_BYTES-1:0] header,
  output logic [31:0]            flags,
  output logic [1:0]             error
);

  logic [7:0] prg;
  logic [7:0] chr;
  logic [7:0] f6;
  logic [7:0] f7;
  logic [3:0] prg_l;
  logic [3:0] chr_l;
  logic       unused_bits;

  assign prg = header[8*HDR_PRG +: 8];
  assign chr = header[8*HDR_CHR +: 8];
  assign f6  = header[8*HDR_FLAGS6 +: 8];
  assign f7  = header[8*HDR_FLAGS7 +: 8];

  assign unused_bits = ^{header[8*HDR_BYTES-1:64], f6[3:2], f7[3:0]};

  always_comb begin
    prg_l = bank_log2(prg);
    // Zero CHR banks is legal (CHR RAM) and encodes as log2 field 0.
    chr_l = (chr == 8'd0) ? 4'b1_000 : bank_log2(chr);

    flags = '0;
    flags[FLAG_MAPPER_LSB +: FLAG_MAPPER_W] = {f7[7:4], f6[7:4]};
    flags[FLAG_PRG_LSB +: FLAG_SIZE_W]      = prg_l[2:0];
    flags[FLAG_CHR_LSB +: FLAG_SIZE_W]      = chr_l[2:0];
    flags[FLAG_VMIRROR]                     = f6[0];
    flags[FLAG_CHR_RAM]                     = (chr == 8'd0);
    flags[FLAG_BATTERY]                     = f6[1];

    if (header[31:0] != INES_MAGIC)
      error = ERR_MAGIC;
    else if (!prg_l[3] || !chr_l[3])
      error = ERR_SIZE;
    else
      error = ERR_NONE;
  end

endmodule

// File: rtl/cart_header_loader.sv
// Fetches the 16-byte iNES header of a cartridge slot over the shared flash byte port,
// validates it and publishes the decoded flags word with a cart-ready qualifier.
module cart_header_loader
  import cart_header_loader_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR      = 24'h100000,
  parameter int          SLOT_SHIFT     = 18,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reload,
  input  logic [3:0]  index,
  input  logic        flash_ready,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        cart_ready,
  output logic [31:0] flags_out,
  output logic [1:0]  header_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  loader_state_t          state;
  logic [3:0]             slot;
  logic [3:0]             cnt;
  logic [TW-1:0]          timer;
  logic [8*HDR_BYTES-1:0] header;
  logic [23:0]            slot_base;
  logic [31:0]            dec_flags;
  logic [1:0]             dec_err;

  assign slot_base = BASE_ADDR + (24'(slot) << SLOT_SHIFT);

  ines_header_decode u_decode (
    .header (header),
    .flags  (dec_flags),
    .error  (dec_err)
  );

  // Reset behaves as a reload of slot 0; a reload in any state aborts and restarts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_FLASH;
      slot         <= '0;
      cnt          <= '0;
      timer        <= '0;
      header       <= '0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b1;
      cart_ready   <= 1'b0;
      flags_out    <= '0;
      header_error <= ERR_NONE;
    end else if (reload) begin
      state        <= WAIT_FLASH;
      slot         <= index;
      cnt          <= '0;
      rd_req       <= 1'b0;
      busy         <= 1'b1;
      cart_ready   <= 1'b0;
      flags_out    <= '0;
      header_error <= ERR_NONE;
    end else begin
      case (state)
        WAIT_FLASH: if (flash_ready) state <= REQ;
        REQ: begin
          rd_req  <= 1'b1;
          rd_addr <= slot_base + {20'd0, cnt};
          timer   <= '0;
          state   <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (rd_valid) begin
            rd_req              <= 1'b0;
            header[{cnt, 3'b000} +: 8] <= rd_data;
            if (cnt == 4'd15) begin
              state <= DECODE;
            end else begin
              cnt   <= cnt + 4'd1;
              state <= REQ;
            end
          end else if (timer == TIMEOUT_LAST) begin
            rd_req       <= 1'b0;
            busy         <= 1'b0;
            flags_out    <= '0;
            header_error <= ERR_TIMEOUT;
            state        <= ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DECODE: begin
          busy <= 1'b0;
          if (dec_err != ERR_NONE) begin
            header_error <= dec_err;
            flags_out    <= '0;
            state        <= ERROR;
          end else begin
            flags_out  <= dec_flags;
            cart_ready <= 1'b1;
            state      <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_header_loader.sv
// Directed bench for cart_header_loader with a latency-3 flash byte-read model.
module tb_cart_header_loader;

  localparam logic [23:0] BASE = 24'h100000;
  localparam int          LAT  = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        reload = 1'b0;
  logic [3:0]  index = '0;
  logic        flash_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        busy;
  logic        cart_ready;
  logic [31:0] flags_out;
  logic [1:0]  header_error;

  int passed = 0;
  int total  = 0;

  logic [7:0]  hdr_mem [16][16];
  logic [23:0] addr_log [$];
  bit          drop_en = 1'b0;
  logic [3:0]  drop_off = '0;
  int          pulse_req = 0;
  int          pulse_ack = 0;
  bit          m_busy = 1'b0;
  bit          m_prev = 1'b0;
  int          m_lat = 0;
  logic [23:0] m_addr = '0;
  logic [23:0] m_rel;

  always #5 clock = ~clock;

  cart_header_loader #(
    .BASE_ADDR      (24'h100000),
    .SLOT_SHIFT     (18),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .reload       (reload),
    .index        (index),
    .flash_ready  (flash_ready),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy),
    .cart_ready   (cart_ready),
    .flags_out    (flags_out),
    .header_error (header_error)
  );

  // Flash model: drives on the falling edge so the DUT samples stable values.
  always @(negedge clock) begin
    rd_valid = 1'b0;
    if (pulse_req != pulse_ack) begin
      rd_valid  = 1'b1;
      rd_data   = 8'hFF;
      pulse_ack = pulse_ack + 1;
    end else if (m_busy) begin
      if (!rd_req) begin
        m_busy = 1'b0;
      end else if (m_lat == 1) begin
        m_rel    = m_addr - BASE;
        rd_valid = 1'b1;
        rd_data  = hdr_mem[m_rel[21:18]][m_rel[3:0]];
        m_busy   = 1'b0;
      end else begin
        m_lat = m_lat - 1;
      end
    end
    if (rd_req && !m_prev) begin
      addr_log.push_back(rd_addr);
      m_addr = rd_addr;
      if (!(drop_en && rd_addr[3:0] == drop_off)) begin
        m_busy = 1'b1;
        m_lat  = LAT;
      end
    end
    m_prev = rd_req;
  end

  task automatic set_header(input int slot, input logic [7:0] m3, input logic [7:0] p,
                            input logic [7:0] c, input logic [7:0] f6, input logic [7:0] f7);
    for (int i = 0; i < 16; i++) hdr_mem[slot][i] = 8'h00;
    hdr_mem[slot][0] = 8'h4E;
    hdr_mem[slot][1] = 8'h45;
    hdr_mem[slot][2] = 8'h53;
    hdr_mem[slot][3] = m3;
    hdr_mem[slot][4] = p;
    hdr_mem[slot][5] = c;
    hdr_mem[slot][6] = f6;
    hdr_mem[slot][7] = f7;
  endtask

  task automatic do_reload(input logic [3:0] idx);
    @(negedge clock);
    index  = idx;
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({rd_req, rd_addr, busy, cart_ready, flags_out, header_error} !==
        {1'b0, 24'h0, 1'b1, 1'b0, 32'h0, 2'd0}) begin
      $display("FAIL reset_values: got req=%b addr=%h busy=%b ready=%b flags=%h err=%0d, expected 0 0 1 0 0 0",
               rd_req, rd_addr, busy, cart_ready, flags_out, header_error);
    end else passed++;
  endtask

  task automatic test_flash_wait();
    bit bad = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rd_req !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL flash_wait_idle: rd_req or busy changed while flash_ready low, expected req=0 busy=1");
    else passed++;
    flash_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (rd_req !== 1'b1 || rd_addr !== 24'h100000)
      $display("FAIL first_req: got req=%b addr=%h, expected req=1 addr=100000", rd_req, rd_addr);
    else passed++;
  endtask

  task automatic test_mario();
    bit ok;
    int bad = 0;
    wait_idle(1000, ok);
    total++;
    if (!ok) $display("FAIL mario_done: busy still 1 after 1000 cycles, expected 0");
    else passed++;
    if (addr_log.size() != 16) bad++;
    else for (int i = 0; i < 16; i++) if (addr_log[i] !== 24'h100000 + 24'(i)) bad++;
    total++;
    if (bad != 0) $display("FAIL mario_addrs: %0d bad of %0d reads, expected 16 reads at 100000..10000F",
                           bad, addr_log.size());
    else passed++;
    total++;
    if ({cart_ready, busy, header_error, flags_out} !== {1'b1, 1'b0, 2'd0, 32'h00004100})
      $display("FAIL mario_result: got ready=%b busy=%b err=%0d flags=%h, expected 1 0 0 00004100",
               cart_ready, busy, header_error, flags_out);
    else passed++;
  endtask

  task automatic test_slot3();
    bit ok;
    int bad = 0;
    addr_log.delete();
    do_reload(4'd3);
    total++;
    if (cart_ready !== 1'b0 || busy !== 1'b1 || flags_out !== 32'h0)
      $display("FAIL reload_clear: got ready=%b busy=%b flags=%h, expected 0 1 0", cart_ready, busy, flags_out);
    else passed++;
    wait_idle(1000, ok);
    if (addr_log.size() != 16) bad++;
    else for (int i = 0; i < 16; i++) if (addr_log[i] !== 24'h1C0000 + 24'(i)) bad++;
    total++;
    if (!ok || bad != 0) $display("FAIL slot3_addrs: done=%b bad=%0d, expected 16 reads from 1C0000", ok, bad);
    else passed++;
    total++;
    if ({cart_ready, header_error, flags_out} !== {1'b1, 2'd0, 32'h00018301})
      $display("FAIL slot3_flags: got ready=%b err=%0d flags=%h, expected 1 0 00018301",
               cart_ready, header_error, flags_out);
    else passed++;
  endtask

  task automatic test_header_errors();
    logic [7:0]  t_m3 [5];
    logic [7:0]  t_p [5];
    logic [7:0]  t_c [5];
    logic [1:0]  t_err [5];
    logic [31:0] t_flags [5];
    bit ok;
    t_m3    = '{8'h1B, 8'h1A, 8'h1A, 8'h1B, 8'h1A};
    t_p     = '{8'd2, 8'd3, 8'd8, 8'd0, 8'd1};
    t_c     = '{8'd1, 8'd1, 8'd3, 8'd1, 8'd8};
    t_err   = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    t_flags = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h000018F0};
    for (int i = 0; i < 5; i++) begin
      set_header(i + 4, t_m3[i], t_p[i], t_c[i], 8'h00, 8'hF0);
      do_reload(4'(i + 4));
      wait_idle(1000, ok);
      total++;
      if (!ok || header_error !== t_err[i])
        $display("FAIL hdr_err[%0d]: done=%b err=%0d, expected %0d", i, ok, header_error, t_err[i]);
      else passed++;
      total++;
      if (flags_out !== t_flags[i])
        $display("FAIL hdr_flags[%0d]: got %h, expected %h", i, flags_out, t_flags[i]);
      else passed++;
      total++;
      if (cart_ready !== (t_err[i] == 2'd0))
        $display("FAIL hdr_ready[%0d]: got %b, expected %b", i, cart_ready, t_err[i] == 2'd0);
      else passed++;
    end
  endtask

  task automatic test_timeout();
    bit found = 1'b0;
    int cnt = 0;
    set_header(2, 8'h1A, 8'd2, 8'd1, 8'h01, 8'h00);
    drop_en  = 1'b1;
    drop_off = 4'd5;
    do_reload(4'd2);
    for (int i = 0; i < 500 && !found; i++) begin
      if (rd_req && rd_addr == 24'h180005) found = 1'b1;
      else @(negedge clock);
    end
    if (found) begin
      cnt = 1;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clock);
        if (rd_req) cnt++;
        else break;
      end
    end
    drop_en = 1'b0;
    total++;
    if (cnt != 4096) $display("FAIL timeout_len: rd_req high %0d cycles (found=%b), expected 4096", cnt, found);
    else passed++;
    total++;
    if ({header_error, busy, cart_ready, flags_out} !== {2'd3, 1'b0, 1'b0, 32'h0})
      $display("FAIL timeout_state: got err=%0d busy=%b ready=%b flags=%h, expected 3 0 0 0",
               header_error, busy, cart_ready, flags_out);
    else passed++;
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    bit ok;
    int bad = 0;
    set_header(1, 8'h1A, 8'd1, 8'd2, 8'h21, 8'h40);
    drop_en  = 1'b1;
    drop_off = 4'd7;
    do_reload(4'd0);
    for (int i = 0; i < 500 && !found; i++) begin
      if (rd_req && rd_addr == 24'h100007) found = 1'b1;
      else @(negedge clock);
    end
    @(negedge clock);
    @(negedge clock);
    index   = 4'd1;
    reload  = 1'b1;
    drop_en = 1'b0;
    @(posedge clock);
    #1;
    reload = 1'b0;
    pulse_req++;
    addr_log.delete();
    total++;
    if (!found || rd_req !== 1'b0)
      $display("FAIL abort_drop: found=%b rd_req=%b after reload, expected 1 0", found, rd_req);
    else passed++;
    wait_idle(1000, ok);
    if (addr_log.size() != 16) bad++;
    else for (int i = 0; i < 16; i++) if (addr_log[i] !== 24'h140000 + 24'(i)) bad++;
    total++;
    if (!ok || bad != 0) $display("FAIL abort_addrs: done=%b bad=%0d, expected 16 reads from 140000", ok, bad);
    else passed++;
    total++;
    if ({cart_ready, header_error, flags_out} !== {1'b1, 2'd0, 32'h00004842})
      $display("FAIL abort_flags: got ready=%b err=%0d flags=%h, expected 1 0 00004842",
               cart_ready, header_error, flags_out);
    else passed++;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    bit ok;
    do_reload(4'd3);
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clock);
      if (rd_req && rd_addr > 24'h1C0002) found = 1'b1;
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (!found || {rd_req, rd_addr, busy, cart_ready, flags_out, header_error} !==
        {1'b0, 24'h0, 1'b1, 1'b0, 32'h0, 2'd0})
      $display("FAIL async_reset_load: found=%b req=%b addr=%h busy=%b, expected 1 0 000000 1",
               found, rd_req, rd_addr, busy);
    else passed++;
    @(negedge clock);
    addr_log.delete();
    reset_n = 1'b1;
    wait_idle(1000, ok);
    total++;
    if (!ok || addr_log.size() != 16 || addr_log[0] !== 24'h100000 || flags_out !== 32'h00004100)
      $display("FAIL reset_reload_slot0: done=%b reads=%0d flags=%h, expected 1 16 00004100",
               ok, addr_log.size(), flags_out);
    else passed++;
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({cart_ready, busy, flags_out, header_error} !== {1'b0, 1'b1, 32'h0, 2'd0})
      $display("FAIL async_reset_done: got ready=%b busy=%b flags=%h err=%0d, expected 0 1 0 0",
               cart_ready, busy, flags_out, header_error);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < 16; s++) set_header(s, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_header(0, 8'h1A, 8'd2, 8'd1, 8'h01, 8'h00);
    set_header(3, 8'h1A, 8'd8, 8'd0, 8'h12, 8'h00);
    test_reset();
    test_flash_wait();
    test_mario();
    test_slot3();
    test_header_errors();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
